// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmit types and constants (PARITY state exists only with UART_TX_PARITY_EN)
package uart_pkg;
   localparam int UART_DATA_BITS = 8;
   localparam int UART_DEFAULT_CLKS_PER_BIT = 868;
`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} uart_tx_state_t;
`endif
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running bit-period counter, cleared on frame load so bit edges align to the start edge
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   output logic o_baud_done
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [CW-1:0] r_cnt;
   assign o_baud_done = r_cnt == CW'(CLKS_PER_BIT - 1);
   // count clocks within a bit, wrapping at the bit end or restarting on load
   always_ff @(posedge clk or posedge reset)
      if (reset) r_cnt <= '0;
      else r_cnt <= (i_clear | o_baud_done) ? '0 : r_cnt + CW'(1);
endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and shifts them out as 8N1 frames (8E1 with UART_TX_PARITY_EN)
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] fifo_data,
   input  logic       fifo_empty,
   output logic       fifo_read,
   output logic       tx,
   output logic       busy
);
   uart_tx_state_t r_state, w_state_nxt;
   logic [7:0] r_shift, w_shift_nxt;
   logic [2:0] r_bit, w_bit_nxt;
   logic       r_tx, w_tx_nxt;
   logic       w_load, w_baud_done;
`ifdef UART_TX_PARITY_EN
   logic       r_parity, w_parity_nxt;
`endif
   assign w_load = enable & ~fifo_empty & (r_state == IDLE | (r_state == STOP & w_baud_done));
   assign fifo_read = w_load;
   assign tx = r_tx;
   assign busy = r_state != IDLE;
   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (w_load),
      .o_baud_done(w_baud_done)
   );
   // frame sequencing: load a byte, then advance one bit slot per baud period
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_bit_nxt = r_bit;
      w_tx_nxt = r_tx;
`ifdef UART_TX_PARITY_EN
      w_parity_nxt = r_parity;
`endif
      if (w_load) begin
         w_state_nxt = START;
         w_shift_nxt = fifo_data;
         w_tx_nxt = 1'b0;
`ifdef UART_TX_PARITY_EN
         w_parity_nxt = ^fifo_data;
`endif
      end else if (w_baud_done) begin
         case (r_state)
            START: begin
               w_state_nxt = DATA;
               w_tx_nxt = r_shift[0];
            end
            DATA: begin
               w_shift_nxt = r_shift >> 1;
               w_bit_nxt = r_bit + 3'd1;
               if (r_bit == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
                  w_tx_nxt = r_parity;
`else
                  w_state_nxt = STOP;
                  w_tx_nxt = 1'b1;
`endif
               end else w_tx_nxt = r_shift[1];
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               w_state_nxt = STOP;
               w_tx_nxt = 1'b1;
            end
`endif
            STOP: begin
               w_state_nxt = IDLE;
               w_tx_nxt = 1'b1;
            end
            default: w_state_nxt = r_state;
         endcase
      end
   end
   // state and datapath registers; reset forces the line to mark immediately
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_bit <= '0;
         r_tx <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_bit <= w_bit_nxt;
         r_tx <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
         r_parity <= w_parity_nxt;
`endif
      end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed checks of uart_tx_serializer with CLKS_PER_BIT=4 (parity frames with UART_TX_PARITY_EN)
module tb_uart_tx_serializer;
   localparam int C = 4;
`ifdef UART_TX_PARITY_EN
   localparam int FL = 11 * C;
`else
   localparam int FL = 10 * C;
`endif
   logic clk = 1'b0;
   logic reset, enable, fifo_empty, fifo_read, tx, busy;
   logic [7:0] fifo_data;
   logic [7:0] q[$];
   int total = 0, bad = 0, cyc = 0, pops = 0, last_pop = -1, prev_pop = -1;
   always #5 clk = ~clk;
   uart_tx_serializer #(.CLKS_PER_BIT(C)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .fifo_data (fifo_data),
      .fifo_empty(fifo_empty),
      .fifo_read (fifo_read),
      .tx        (tx),
      .busy      (busy)
   );
   function automatic logic exp_tx(input logic [7:0] b, input int i);
      int k;
      k = i / C;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^b;
`endif
      return 1'b1;
   endfunction
   task automatic sync_fifo();
      fifo_empty = q.size() == 0;
      fifo_data = fifo_empty ? 8'h00 : q[0];
   endtask
   task automatic push(input logic [7:0] b);
      q.push_back(b);
      sync_fifo();
      #1;
   endtask
   task automatic step();
      logic rd;
      #1;
      rd = fifo_read;
      @(posedge clk);
      #1;
      cyc++;
      if (rd) begin
         pops++;
         prev_pop = last_pop;
         last_pop = cyc;
         if (q.size() > 0) void'(q.pop_front());
         sync_fifo();
      end
   endtask
   task automatic test_reset();
      reset = 1'b1;
      enable = 1'b1;
      sync_fifo();
      repeat (2) @(posedge clk);
      #1;
      total += 3;
      if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      if (fifo_read !== 1'b0) begin bad++; $display("FAIL reset_read: got %b want 0", fifo_read); end
      reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step();
         total += 3;
         if (tx !== 1'b1) begin bad++; $display("FAIL idle_tx[%0d]: got %b want 1", i, tx); end
         if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy[%0d]: got %b want 0", i, busy); end
         if (fifo_read !== 1'b0) begin bad++; $display("FAIL idle_read[%0d]: got %b want 0", i, fifo_read); end
      end
   endtask
   task automatic test_single();
      int p0;
      p0 = pops;
      push(8'hA5);
      total++;
      if (fifo_read !== 1'b1) begin bad++; $display("FAIL single_strobe: got %b want 1", fifo_read); end
      step();
      for (int i = 0; i < FL; i++) begin
         total += 3;
         if (tx !== exp_tx(8'hA5, i)) begin bad++; $display("FAIL single_tx[%0d]: got %b want %b", i, tx, exp_tx(8'hA5, i)); end
         if (busy !== 1'b1) begin bad++; $display("FAIL single_busy[%0d]: got %b want 1", i, busy); end
         if (fifo_read !== 1'b0) begin bad++; $display("FAIL single_read[%0d]: got %b want 0", i, fifo_read); end
         step();
      end
      total += 3;
      if (busy !== 1'b0) begin bad++; $display("FAIL single_end_busy: got %b want 0", busy); end
      if (tx !== 1'b1) begin bad++; $display("FAIL single_end_tx: got %b want 1", tx); end
      if (pops !== p0 + 1) begin bad++; $display("FAIL single_pops: got %0d want %0d", pops, p0 + 1); end
   endtask
   task automatic test_back_to_back();
      int p0;
      logic [7:0] b;
      p0 = pops;
      push(8'h00);
      push(8'hFF);
      step();
      for (int i = 0; i < 2 * FL; i++) begin
         b = i < FL ? 8'h00 : 8'hFF;
         total += 2;
         if (tx !== exp_tx(b, i % FL)) begin bad++; $display("FAIL b2b_tx[%0d]: got %b want %b", i, tx, exp_tx(b, i % FL)); end
         if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy[%0d]: got %b want 1", i, busy); end
         step();
      end
      total += 3;
      if (pops !== p0 + 2) begin bad++; $display("FAIL b2b_pops: got %0d want %0d", pops, p0 + 2); end
      if (last_pop - prev_pop !== FL) begin bad++; $display("FAIL b2b_spacing: got %0d want %0d", last_pop - prev_pop, FL); end
      if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
   endtask
   task automatic test_enable_drop();
      int p0;
      push(8'h55);
      push(8'h3C);
      step();
      p0 = pops;
      for (int i = 0; i < FL; i++) begin
         if (i == 3 * C + 1) enable = 1'b0;
         total += 2;
         if (tx !== exp_tx(8'h55, i)) begin bad++; $display("FAIL drop_tx[%0d]: got %b want %b", i, tx, exp_tx(8'h55, i)); end
         if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy[%0d]: got %b want 1", i, busy); end
         step();
      end
      for (int i = 0; i < 20; i++) begin
         total += 3;
         if (tx !== 1'b1) begin bad++; $display("FAIL drop_idle_tx[%0d]: got %b want 1", i, tx); end
         if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle_busy[%0d]: got %b want 0", i, busy); end
         if (fifo_read !== 1'b0) begin bad++; $display("FAIL drop_idle_read[%0d]: got %b want 0", i, fifo_read); end
         step();
      end
      total++;
      if (pops !== p0) begin bad++; $display("FAIL drop_pops: got %0d want %0d", pops, p0); end
      enable = 1'b1;
      #1;
      total++;
      if (fifo_read !== 1'b1) begin bad++; $display("FAIL resume_strobe: got %b want 1", fifo_read); end
      step();
      for (int i = 0; i < FL; i++) begin
         total += 2;
         if (tx !== exp_tx(8'h3C, i)) begin bad++; $display("FAIL resume_tx[%0d]: got %b want %b", i, tx, exp_tx(8'h3C, i)); end
         if (busy !== 1'b1) begin bad++; $display("FAIL resume_busy[%0d]: got %b want 1", i, busy); end
         step();
      end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL resume_end_busy: got %b want 0", busy); end
   endtask
`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals [2];
      logic pe [2];
      vals[0] = 8'h07;
      vals[1] = 8'h03;
      pe[0] = 1'b1;
      pe[1] = 1'b0;
      for (int v = 0; v < 2; v++) begin
         push(vals[v]);
         step();
         for (int i = 0; i < FL; i++) begin
            total += 2;
            if (i >= 9 * C && i < 10 * C && tx !== pe[v]) begin bad++; $display("FAIL parity_bit[%0d][%0d]: got %b want %b", v, i, tx, pe[v]); end
            if (busy !== 1'b1) begin bad++; $display("FAIL parity_busy[%0d][%0d]: got %b want 1", v, i, busy); end
            step();
         end
         total++;
         if (busy !== 1'b0) begin bad++; $display("FAIL parity_len[%0d]: busy=%b want 0 after %0d cycles", v, busy, FL); end
      end
   endtask
`endif
   task automatic test_async_reset();
      int p0;
      push(8'h96);
      step();
      for (int i = 0; i < 6 * C; i++) step();
      total += 2;
      if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
      if (tx !== 1'b0) begin bad++; $display("FAIL mid_tx: got %b want 0", tx); end
      #2;
      reset = 1'b1;
      #1;
      total += 2;
      if (tx !== 1'b1) begin bad++; $display("FAIL async_tx: got %b want 1", tx); end
      if (busy !== 1'b0) begin bad++; $display("FAIL async_busy: got %b want 0", busy); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      p0 = pops;
      push(8'h5A);
      step();
      for (int i = 0; i < FL; i++) begin
         total++;
         if (tx !== exp_tx(8'h5A, i)) begin bad++; $display("FAIL after_rst_tx[%0d]: got %b want %b", i, tx, exp_tx(8'h5A, i)); end
         step();
      end
      total += 2;
      if (busy !== 1'b0) begin bad++; $display("FAIL after_rst_busy: got %b want 0", busy); end
      if (pops !== p0 + 1) begin bad++; $display("FAIL after_rst_pops: got %0d want %0d", pops, p0 + 1); end
   endtask
   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_enable_drop();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Transmit-side serializer of the UART peripheral; sits directly downstream of the UART transmit FIFO. Whenever the FIFO reports data and transmission is enabled, it pops one byte and shifts it out on the serial line as an 8N1 frame (optionally 8E1). Frames go out back-to-back with no idle gap while the FIFO stays non-empty.

## Interface
- CLKS_PER_BIT, default 868 — clock cycles per serial bit (100 MHz / 115200); legal range ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  permits starting new frames; a frame in progress always completes.
- fifo_data  input  8  byte at the FIFO read pointer (combinational FIFO output).
- fifo_empty  input  1  high when the FIFO holds no data (FIFO `lowword` output).
- fifo_read  output  1  one-cycle pop strobe to the FIFO (`read_req`).
- tx  output  1  serial line; idle/mark = 1.
- busy  output  1  high from the first start-bit cycle through the last stop-bit cycle.

## Operation
- Reset values: tx=1, busy=0, fifo_read=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- Load condition: `load = enable & ~fifo_empty & (state==IDLE | (state==STOP & baud_done))`.
- fifo_read = load, combinational, so the FIFO advances on the same edge that captures fifo_data into the shift register. This gives exactly one pop per frame and never a pop while empty.
- On load: shift_reg ← fifo_data, baud counter ← 0, state → START, tx ← 0.
- START: tx=0 for CLKS_PER_BIT cycles, then → DATA with tx ← shift_reg[0].
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The shift register shifts right at each bit end. The 3-bit bit counter wraps 7→0 on exit. After bit 7 → PARITY (macro) or STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the final cycle, go → START if load, else → IDLE.
- baud_done is high on the cycle the baud counter equals CLKS_PER_BIT−1; the counter then wraps to 0. Counter width is $clog2(CLKS_PER_BIT).
- busy = (state != IDLE).
- enable deasserted mid-frame: the frame finishes and the block returns to IDLE. No pop occurs.
- Reset asserted mid-frame: tx returns to 1 immediately (asynchronously). The partial frame is abandoned and the popped byte is lost.

## Timing
- fifo_empty falls with enable=1 in IDLE → fifo_read high in the same cycle → tx=0 from the next edge.
- Frame length: 10·CLKS_PER_BIT cycles (11·CLKS_PER_BIT with parity), measured from the start-bit edge to the next start-bit edge or to the return to IDLE.
- Back-to-back frames: the start bit of frame N+1 begins on the edge immediately after the last stop-bit cycle of frame N. There is zero idle gap.
- fifo_read is never high for two consecutive cycles. Minimum spacing between pulses is one frame length.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is inserted between DATA and STOP. tx = ^byte (even parity) for CLKS_PER_BIT cycles. Parity is computed at load from fifo_data and stored in a 1-bit register.
- Not defined: no PARITY state and no parity register. Frame is 8N1.

## Structure
- Shared package uart_pkg:
  - state enum `uart_tx_state_t`
  - `UART_DATA_BITS = 8`
  - `UART_DEFAULT_CLKS_PER_BIT = 868`
- Sub-module uart_baud_gen (parameter CLKS_PER_BIT): free-running counter with a synchronous clear input and a `baud_done` output. It is cleared on load so that bit boundaries align to the start edge.

## Test plan
- Reset, then idle with fifo_empty=1: tx=1, busy=0, fifo_read=0 for 100 cycles.
- CLKS_PER_BIT=4, single byte 0xA5 → one fifo_read pulse, then tx reads 0 ×4, then bits 1,0,1,0,0,1,0,1 (4 cycles each), then 1 ×4. busy is high for 40 cycles, then the block returns to IDLE.
- Two queued bytes 0x00 then 0xFF → exactly two fifo_read pulses 40 cycles apart. The second start bit immediately follows the first stop bit, with no idle cycle.
- With UART_TX_PARITY_EN, byte 0x07 → parity bit 1 and a frame length of 44 cycles. With byte 0x03 → parity bit 0.
- enable dropped during the 3rd data bit with the FIFO non-empty → the current frame completes and tx stays 1 afterwards. No further fifo_read occurs until enable returns, and the first frame starts one cycle later.
- Reset asserted mid-DATA → tx=1 and busy=0 without waiting for a clock edge. After release, the next frame is correct.
